// File: rtl/alu_seq_core.sv
// Multi-cycle ALU core: run/done/busy handshake, iterative Booth MUL and restoring DIV.
// Optional ALU_FLAGS_EN builds the {Z,C,V,DZ} flags register.
module alu_seq_core #(
    parameter int DW   = 8,
    parameter int NREG = 2,
    parameter int RW   = $clog2(NREG),
    parameter int SHW  = $clog2(DW),
    parameter int IW   = 4 + SHW + RW + DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [IW-1:0]   DIN,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] G,
    output logic [3:0]      flags
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC} state_t;

    localparam logic [3:0] OP_MOVI = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd10;
    localparam logic [3:0] OP_DEC  = 4'd11;
    localparam logic [3:0] OP_ADD  = 4'd12;
    localparam logic [3:0] OP_SUB  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_DIV  = 4'd15;

    state_t           state_q, state_d;
    logic [IW-1:0]    ir;
    logic [DW-1:0]    a;
    logic [DW-1:0]    r [NREG];
    logic [SHW-1:0]   cnt;
    logic [DW:0]      acc, acc_n;
    logic [DW-1:0]    q, q_n;
    logic             q1, q1_n;
    logic [DW:0]      sum, rs, diff;
    logic [DW:0]      add_r;
    logic [DW-1:0]    sub_r;
    logic [DW-1:0]    lo;
    logic [2*DW-1:0]  res;

    logic [3:0]       op;
    logic [SHW-1:0]   sh;
    logic [RW-1:0]    rx;
    logic [DW-1:0]    imm;
    logic             iter, last, fin;

    assign op   = ir[IW-1 -: 4];
    assign sh   = ir[DW+RW +: SHW];
    assign rx   = ir[DW +: RW];
    assign imm  = ir[DW-1:0];
    assign iter = (op == OP_MUL) || (op == OP_DIV);
    assign last = (cnt == SHW'(DW-1));
    assign fin  = (state_q == S_EXEC) && (!iter || last);
    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_DECODE;
            S_DECODE: state_d = (op == OP_MOVI) ? S_IDLE : S_EXEC;
            S_EXEC:   if (!iter || last) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // One iteration step: Booth add/sub + arithmetic shift, or restoring divide
    always_comb begin
        acc_n = acc;
        q_n   = q;
        q1_n  = q1;
        sum   = '0;
        rs    = '0;
        diff  = '0;
        if (op == OP_MUL) begin
            case ({q[0], q1})
                2'b01:   sum = acc + {a[DW-1], a};
                2'b10:   sum = acc - {a[DW-1], a};
                default: sum = acc;
            endcase
            acc_n = {sum[DW], sum[DW:1]};
            q_n   = {sum[0], q[DW-1:1]};
            q1_n  = q[0];
        end else begin
            rs   = {acc[DW-1:0], q[DW-1]};
            diff = rs - {1'b0, imm};
            if (diff[DW]) begin
                acc_n = rs;
                q_n   = {q[DW-2:0], 1'b0};
            end else begin
                acc_n = diff;
                q_n   = {q[DW-2:0], 1'b1};
            end
        end
    end

    assign add_r = {1'b0, a} + {1'b0, imm};
    assign sub_r = a - imm;

    always_comb begin
        lo  = '0;
        res = '0;
        case (op)
            OP_AND:  lo = a & imm;
            OP_OR:   lo = a | imm;
            OP_NAND: lo = ~(a & imm);
            OP_XOR:  lo = a ^ imm;
            OP_XNOR: lo = ~(a ^ imm);
            OP_NOR:  lo = ~(a | imm);
            OP_NOT:  lo = ~a;
            OP_SHR:  lo = a >> sh;
            OP_INC:  lo = a + DW'(1);
            OP_DEC:  lo = a - DW'(1);
            OP_SUB:  lo = sub_r;
            default: lo = '0;
        endcase
        case (op)
            OP_SHL:         res = {{DW{1'b0}}, a} << sh;
            OP_ADD:         res = {{(DW-1){1'b0}}, add_r};
            OP_MUL, OP_DIV: res = {acc_n[DW-1:0], q_n};
            default:        res = {{DW{1'b0}}, lo};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir   <= '0;
            a    <= '0;
            cnt  <= '0;
            acc  <= '0;
            q    <= '0;
            q1   <= 1'b0;
            G    <= '0;
            done <= 1'b0;
            for (int i = 0; i < NREG; i++) r[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: if (run) ir <= DIN;
                S_DECODE: begin
                    a   <= r[rx];
                    cnt <= '0;
                    acc <= '0;
                    q1  <= 1'b0;
                    q   <= (op == OP_MUL) ? imm : r[rx];
                    if (op == OP_MOVI) begin
                        r[rx] <= imm;
                        done  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (iter) begin
                        acc <= acc_n;
                        q   <= q_n;
                        q1  <= q1_n;
                        cnt <= cnt + SHW'(1);
                    end
                    if (fin) begin
                        G    <= res;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_q;
    logic       fz, fc, fv, fdz;

    always_comb begin
        fz  = (res == '0);
        fc  = 1'b0;
        fv  = 1'b0;
        fdz = (op == OP_DIV) && (imm == '0);
        if (op == OP_ADD) begin
            fc = add_r[DW];
            fv = ~(a[DW-1] ^ imm[DW-1]) & (add_r[DW-1] ^ a[DW-1]);
        end else if (op == OP_SUB) begin
            fc = (a < imm);
            fv = (a[DW-1] ^ imm[DW-1]) & (sub_r[DW-1] ^ a[DW-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)      flags_q <= '0;
        else if (fin) flags_q <= {fz, fc, fv, fdz};
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core (DW=8, NREG=2); flag expectations
// follow ALU_FLAGS_EN when the bench is built with it.
module tb_alu_seq_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] DIN;
    logic        busy;
    logic        done;
    logic [15:0] G;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    alu_seq_core dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .DIN   (DIN),
        .busy  (busy),
        .done  (done),
        .G     (G),
        .flags (flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] din;
        logic [15:0] g;
        logic [3:0]  lat;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs [32];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_fl(input logic [3:0] f);
`ifdef ALU_FLAGS_EN
        return f;
`else
        return (f & 4'h0);
`endif
    endfunction

    // Start one op at a negedge; return edges until done, 0 on timeout
    task automatic issue(input logic [15:0] instr, output int lat,
                         output bit bsy_ok);
        lat    = 0;
        bsy_ok = 1'b1;
        DIN    = instr;
        run    = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            run = 1'b0;
            if (done) begin
                lat = e;
                if (busy) bsy_ok = 1'b0;
                break;
            end
            if (!busy) bsy_ok = 1'b0;
        end
    endtask

    initial begin
        int  lat;
        bit  bok;
        int  ndone;

        vecs[0]  = '{16'h0005, 16'h0000, 4'd2,  4'b0000};
        vecs[1]  = '{16'hC0FF, 16'h0104, 4'd3,  4'b0100};
        vecs[2]  = '{16'h01FD, 16'h0104, 4'd2,  4'b0100};
        vecs[3]  = '{16'hE107, 16'hFFEB, 4'd10, 4'b0000};
        vecs[4]  = '{16'h0064, 16'hFFEB, 4'd2,  4'b0000};
        vecs[5]  = '{16'hF007, 16'h020E, 4'd10, 4'b0000};
        vecs[6]  = '{16'hF000, 16'h64FF, 4'd10, 4'b0001};
        vecs[7]  = '{16'h0081, 16'h64FF, 4'd2,  4'b0001};
        vecs[8]  = '{16'h8600, 16'h0408, 4'd3,  4'b0000};
        vecs[9]  = '{16'h9600, 16'h0010, 4'd3,  4'b0000};
        vecs[10] = '{16'h0000, 16'h0010, 4'd2,  4'b0000};
        vecs[11] = '{16'hB000, 16'h00FF, 4'd3,  4'b0000};
        vecs[12] = '{16'hA000, 16'h0001, 4'd3,  4'b0000};
        vecs[13] = '{16'hC000, 16'h0000, 4'd3,  4'b1000};
        vecs[14] = '{16'h003C, 16'h0000, 4'd2,  4'b1000};
        vecs[15] = '{16'h300F, 16'h00F3, 4'd3,  4'b0000};
        vecs[16] = '{16'h400F, 16'h0033, 4'd3,  4'b0000};
        vecs[17] = '{16'h500F, 16'h00CC, 4'd3,  4'b0000};
        vecs[18] = '{16'h600F, 16'h00C0, 4'd3,  4'b0000};
        vecs[19] = '{16'h7000, 16'h00C3, 4'd3,  4'b0000};
        vecs[20] = '{16'hD00F, 16'h002D, 4'd3,  4'b0000};
        vecs[21] = '{16'hD050, 16'h00EC, 4'd3,  4'b0100};
        vecs[22] = '{16'hC050, 16'h008C, 4'd3,  4'b0010};
        vecs[23] = '{16'h00FF, 16'h008C, 4'd2,  4'b0010};
        vecs[24] = '{16'hA000, 16'h0000, 4'd3,  4'b1000};
        vecs[25] = '{16'hF010, 16'h0F0F, 4'd10, 4'b0000};
        vecs[26] = '{16'h0080, 16'h0F0F, 4'd2,  4'b0000};
        vecs[27] = '{16'hE080, 16'h4000, 4'd10, 4'b0000};
        vecs[28] = '{16'hE001, 16'hFF80, 4'd10, 4'b0000};
        vecs[29] = '{16'h8E00, 16'h4000, 4'd3,  4'b0000};
        vecs[30] = '{16'h9E00, 16'h0001, 4'd3,  4'b0000};
        vecs[31] = '{16'h8000, 16'h0080, 4'd3,  4'b0000};

        rst = 1'b1;
        run = 1'b0;
        DIN = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_G",     32'(G),     32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            issue(vecs[i].din, lat, bok);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_G", i), 32'(G), 32'(vecs[i].g));
            check($sformatf("v%0d_flags", i), 32'(flags),
                  32'(exp_fl(vecs[i].fl)));
            check($sformatf("v%0d_busy", i), 32'(bok), 32'h1);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), 32'(done), 32'h0);
        end

        // Reset at edge 4 of a MUL aborts it and clears registers
        DIN = 16'hE107;
        run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_G",    32'(G),    32'h0);
        rst = 1'b0;
        ndone = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_nodone", 32'(ndone), 32'h0);
        issue(16'hC000, lat, bok);
        check("abort_r0_lat", 32'(lat), 32'd3);
        check("abort_r0", 32'(G), 32'h0);
        @(negedge clk);
        issue(16'hC1FF, lat, bok);
        check("abort_r1", 32'(G), 32'h00FF);
        @(negedge clk);

        // Second run pulse while busy is ignored
        issue(16'h0102, lat, bok);
        @(negedge clk);
        DIN = 16'hE103;
        run = 1'b1;
        ndone = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            run = 1'b0;
            if (e == 3) begin
                DIN = 16'hC1FF;
                run = 1'b1;
            end
            if (done) ndone++;
        end
        check("busy_run_ndone", 32'(ndone), 32'd1);
        check("busy_run_G", 32'(G), 32'h0006);
        check("busy_run_idle", 32'(busy), 32'h0);

        // run held high: next op starts at the done edge
        issue(16'h003C, lat, bok);
        @(negedge clk);
        DIN = 16'h100F;
        run = 1'b1;
        lat = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = e;
                break;
            end
        end
        check("hold_lat1", 32'(lat), 32'd3);
        check("hold_G1", 32'(G), 32'h000C);
        DIN = 16'h20F0;
        lat = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            run = 1'b0;
            if (done) begin
                lat = e;
                break;
            end
        end
        check("hold_lat2", 32'(lat), 32'd3);
        check("hold_G2", 32'(G), 32'h00FC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
